// File: rtl/nv_nvdla_csc_wl_seq_pkg.sv
// Shared types and width helpers for the CSC compressed-weight sequencer.
package nv_nvdla_csc_wl_seq_pkg;

    // Group sequencing states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Width of the decoder mask-enable bus
    localparam int unsigned MASK_EN_W = 10;

    // Byte-count width: must hold 0 .. 2*ATOMC inclusive
    function automatic int unsigned cnt_w(input int unsigned atomc);
        return $clog2(2 * atomc) + 1;
    endfunction

    // Popcount width: must hold 0 .. ATOMC inclusive
    function automatic int unsigned pop_w(input int unsigned atomc);
        return $clog2(atomc) + 1;
    endfunction

endpackage

// File: rtl/nv_nvdla_csc_wl_popcnt.sv
// Combinational population count of one sparsity mask.
module nv_nvdla_csc_wl_popcnt
    import nv_nvdla_csc_wl_seq_pkg::*;
#(
    parameter int unsigned ATOMC = 8
) (
    input  logic [ATOMC-1:0]          mask,
    output logic [pop_w(ATOMC)-1:0]   count
);

    localparam int unsigned POP_W = pop_w(ATOMC);

    // Sum of set lanes
    always_comb begin
        count = '0;
        for (int i = 0; i < ATOMC; i++) begin
            count = count + POP_W'(mask[i]);
        end
    end

endmodule

// File: rtl/nv_nvdla_csc_wl_seq.sv
// Compressed-weight sequencer: pairs each kernel's sparsity mask with its
// packed non-zero bytes and issues one beat per kernel to the WL decoder.
module nv_nvdla_csc_wl_seq
    import nv_nvdla_csc_wl_seq_pkg::*;
#(
    parameter int unsigned ATOMC = 8,
    parameter int unsigned BPE   = 8,
    parameter int unsigned ATOMK = 8
) (
    input  logic                      nvdla_core_clk,
    input  logic                      nvdla_core_rstn,
    input  logic                      op_en,
    input  logic                      cfg_comp,
    input  logic [15:0]               cfg_kernel_num,
    input  logic [15:0]               cfg_entry_num,
    input  logic                      msk_vld,
    output logic                      msk_rdy,
    input  logic [ATOMC-1:0]          msk_data,
    input  logic                      wt_vld,
    output logic                      wt_rdy,
    input  logic [ATOMC*BPE-1:0]      wt_data,
    output logic                      dec_pvld,
    output logic [ATOMC*BPE-1:0]      dec_data,
    output logic [ATOMC-1:0]          dec_mask,
    output logic [MASK_EN_W-1:0]      dec_mask_en,
    output logic [ATOMK-1:0]          dec_sel,
    output logic                      grp_done
);

    localparam int unsigned DATA_W = ATOMC * BPE;
    localparam int unsigned BUF_N  = 2 * ATOMC;
    localparam int unsigned CNT_W  = cnt_w(ATOMC);
    localparam int unsigned POP_W  = pop_w(ATOMC);
    localparam int unsigned SEL_W  = (ATOMK > 1) ? $clog2(ATOMK) : 1;
    localparam int unsigned ENT_W  = 17;
    localparam logic [MASK_EN_W-1:0] MASK_EN_VAL =
        MASK_EN_W'((1 << 8) | ((1 << (ATOMC / 8)) - 1));

    state_e                 state_q;
    state_e                 state_d;

    logic                   comp_q;
    logic [15:0]            kern_num_q;
    logic [15:0]            ent_num_q;
    logic [15:0]            kern_cnt_q;
    logic [ENT_W-1:0]       ent_taken_q;
    logic [SEL_W-1:0]       sel_idx_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic [BPE-1:0]         buf_q [BUF_N];
    logic [BPE-1:0]         buf_d [BUF_N];

    logic [POP_W-1:0]       pop;
    logic [POP_W-1:0]       n;
    logic                   run;
    logic                   start;
    logic                   fire;
    logic                   accept;
    logic                   last;
    logic                   clr;
    logic [DATA_W-1:0]      data_d;

    nv_nvdla_csc_wl_popcnt #(
        .ATOMC (ATOMC)
    ) u_popcnt (
        .mask  (msk_data),
        .count (pop)
    );

    // Handshake and beat-issue qualifiers
    assign run     = (state_q == ST_RUN);
    assign start   = (state_q == ST_IDLE) && op_en;
    assign n       = comp_q ? pop : POP_W'(ATOMC);
    assign fire    = run && (comp_q ? msk_vld : 1'b1) && (cnt_q >= CNT_W'(n));
    assign msk_rdy = fire && comp_q;
    assign wt_rdy  = run && (cnt_q <= CNT_W'(ATOMC)) && (ent_taken_q <= {1'b0, ent_num_q});
    assign accept  = wt_rdy && wt_vld;
    assign last    = (kern_cnt_q == kern_num_q);
    assign clr     = !run || (fire && last);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (op_en) state_d = ST_RUN;
            ST_RUN:  if (fire && last) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Byte aligner: drop the consumed bytes, then append the new entry above what is left
    always_comb begin
        int n_i;
        int pos;
        int src;
        n_i   = fire ? int'(n) : 0;
        pos   = int'(cnt_q) - n_i;
        cnt_d = cnt_q;
        if (fire) begin
            cnt_d = cnt_d - CNT_W'(n);
        end
        if (accept) begin
            cnt_d = cnt_d + CNT_W'(ATOMC);
        end
        for (int i = 0; i < BUF_N; i++) begin
            src      = i + n_i;
            buf_d[i] = (src < BUF_N) ? buf_q[src] : '0;
            if (accept && (i >= pos) && (i < pos + ATOMC)) begin
                buf_d[i] = wt_data[(i - pos) * BPE +: BPE];
            end
            if (clr) begin
                buf_d[i] = '0;
            end
        end
        if (clr) begin
            cnt_d = '0;
        end
    end

    // Beat payload: lowest n buffered bytes, zero above
    always_comb begin
        data_d = '0;
        for (int i = 0; i < ATOMC; i++) begin
            if (i < int'(n)) begin
                data_d[i * BPE +: BPE] = buf_q[i];
            end
        end
    end

    // Aligner storage
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            cnt_q <= '0;
            for (int i = 0; i < BUF_N; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            for (int i = 0; i < BUF_N; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

    // Group configuration and kernel / entry / select counters
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            comp_q      <= 1'b0;
            kern_num_q  <= '0;
            ent_num_q   <= '0;
            kern_cnt_q  <= '0;
            ent_taken_q <= '0;
            sel_idx_q   <= '0;
        end else if (start) begin
            comp_q      <= cfg_comp;
            kern_num_q  <= cfg_kernel_num;
            ent_num_q   <= cfg_entry_num;
            kern_cnt_q  <= '0;
            ent_taken_q <= '0;
            sel_idx_q   <= '0;
        end else begin
            if (fire) begin
                kern_cnt_q <= kern_cnt_q + 16'd1;
                sel_idx_q  <= (sel_idx_q == SEL_W'(ATOMK - 1)) ? '0 : sel_idx_q + SEL_W'(1);
            end
            if (accept) begin
                ent_taken_q <= ent_taken_q + ENT_W'(1);
            end
        end
    end

    // Registered decoder beat and group-done pulse
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            dec_pvld    <= 1'b0;
            dec_data    <= '0;
            dec_mask    <= '0;
            dec_mask_en <= '0;
            dec_sel     <= '0;
            grp_done    <= 1'b0;
        end else begin
            dec_pvld    <= fire;
            dec_data    <= fire ? data_d : '0;
            dec_mask    <= fire ? (comp_q ? msk_data : '1) : '0;
            dec_mask_en <= fire ? MASK_EN_VAL : '0;
            dec_sel     <= fire ? (ATOMK'(1) << sel_idx_q) : '0;
            grp_done    <= (state_q == ST_DONE);
        end
    end

endmodule
